// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data-memory port.
// Byte-addressed RAM of 2**ADDR_W bytes serving LB/LH/LW/LBU/LHU and SB/SH/SW
// with WAIT_CYCLES wait states. It is a three-state machine: IDLE, then WAIT,
// then RESP.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   rd, wr     load / store request; the core holds it while busy=1
//   addr       byte address (ADDR_W bits, no wrap)
//   funct3     RISC-V load/store funct3 (size and sign)
//   wr_data    store data, LSB-aligned
//   rd_data    load result, extended per funct3; holds between responses
//   rd_valid   one-cycle pulse, load result on rd_data
//   busy       combinational stall, high in the accept cycle and in WAIT
//   err        one-cycle pulse with the response: misaligned or illegal funct3
//   parity_err one-cycle pulse with a load response on a byte parity mismatch
//
// Optional feature: define DMEM_PARITY_EN to store one even-parity bit per
// byte and check it on loads. Without it parity_err is tied to 0.
module dmem_responder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              err,
    output logic              parity_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NBYTE = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          f3_q, f3_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                store_q, store_d;
    logic [DATA_W-1:0]   rd_data_d;
    logic                rd_valid_d, err_d, parity_err_d;

    logic [7:0]          mem [DEPTH];

    logic [1:0]          off;
    logic                illegal, misaligned, bad;
    logic [NBYTE-1:0]    be;
    logic [DATA_W-1:0]   rword, shifted, load_val, lane_w;
    logic                mem_we;
    logic                par_bad;

    // Access decode on the latched request
    always_comb begin
        off        = addr_q[1:0];
        illegal    = 1'b0;
        misaligned = 1'b0;
        be         = '0;
        rword      = '0;
        if (store_q) begin
            illegal = f3_q[2] || (f3_q[1:0] == 2'b11);
        end else begin
            illegal = (f3_q == 3'b011) || (f3_q[2:1] == 2'b11);
        end
        case (f3_q[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_q[0];
            default: misaligned = (addr_q[1:0] != 2'b00);
        endcase
        bad = illegal || misaligned;
        case (f3_q[1:0])
            2'b00:   be = NBYTE'(4'b0001 << off);
            2'b01:   be = NBYTE'(4'b0011 << off);
            default: be = NBYTE'(4'b1111);
        endcase
        for (int b = 0; b < int'(NBYTE); b++) begin
            rword[8*b +: 8] = mem[{addr_q[ADDR_W-1:2], 2'(b)}];
        end
        shifted = rword >> {off, 3'b000};
        lane_w  = wdata_q << {off, 3'b000};
        case (f3_q)
            3'b000:  load_val = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            3'b101:  load_val = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: load_val = rword;
        endcase
        mem_we = (state_q == S_RESP) && store_q && !bad;
    end

    // Data RAM: not reset; writes only commit on the RESP edge
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(NBYTE); b++) begin
                if (be[b]) begin
                    mem[{addr_q[ADDR_W-1:2], 2'(b)}] <= lane_w[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic             par_mem [DEPTH];
    logic [NBYTE-1:0] par_mism;

    // Even parity per byte: byte XOR its parity bit must be 0
    always_comb begin
        par_mism = '0;
        for (int b = 0; b < int'(NBYTE); b++) begin
            par_mism[b] = ^{rword[8*b +: 8], par_mem[{addr_q[ADDR_W-1:2], 2'(b)}]};
        end
        par_bad = |(be & par_mism);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(NBYTE); b++) begin
                if (be[b]) begin
                    par_mem[{addr_q[ADDR_W-1:2], 2'(b)}] <= ^lane_w[8*b +: 8];
                end
            end
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    // Stall: accept cycle and wait states, never during reset
    assign busy = reset && (((state_q == S_IDLE) && (rd || wr)) || (state_q == S_WAIT));

    // Next-state and response values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        f3_d         = f3_q;
        wdata_d      = wdata_q;
        store_d      = store_q;
        rd_data_d    = rd_data;
        rd_valid_d   = 1'b0;
        err_d        = 1'b0;
        parity_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd || wr) begin
                    addr_d  = addr;
                    f3_d    = funct3;
                    wdata_d = wr_data;
                    store_d = wr;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d    = S_IDLE;
                err_d      = bad;
                rd_valid_d = !store_q;
                if (bad) begin
                    rd_data_d = '0;
                end else if (!store_q) begin
                    rd_data_d    = load_val;
                    parity_err_d = par_bad;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            f3_q       <= '0;
            wdata_q    <= '0;
            store_q    <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            err        <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            f3_q       <= f3_d;
            wdata_q    <= wdata_d;
            store_q    <= store_d;
            rd_data    <= rd_data_d;
            rd_valid   <= rd_valid_d;
            err        <= err_d;
            parity_err <= parity_err_d;
        end
    end

endmodule
